// File: rtl/rga_bus_writer.sv
`default_nettype none
// ============================================================================
//  Module   : rga_bus_writer
//  Brief    : Queues chip-register writes and issues one per colour-clock
//             slot onto the RGA[8:1] address bus and the data bus.
//             The colour clock is sampled into the 56 MHz domain. Each of its
//             rising edges opens a new slot. A slot either drives the queue
//             head or parks the bus on the NO-OP register with the data
//             driver off.
//  Revision : 1.0  initial release
// ============================================================================
module rga_bus_writer #(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] IDLE_RGA   = 8'hFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cck,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_addr,
    input  logic [15:0] req_data,
    output logic [7:0]  rga,
    output logic [15:0] db_out,
    output logic        db_oen,
    output logic        wr_strobe,
    output logic        busy
);

    localparam int              c_AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [c_AW:0]   c_FULL  = (c_AW + 1)'(FIFO_DEPTH);
    localparam logic [0:0]      c_IDLE  = 1'b0;
    localparam logic [0:0]      c_DRIVE = 1'b1;

    // ------------------------------------------------------------------
    // Colour-clock synchroniser and slot boundary detect
    // ------------------------------------------------------------------
    logic r_s1;
    logic r_s2;
    logic r_s3;
    logic w_slot_start;

    // Two-flop synchroniser for cck, plus a history flop for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= cck;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_slot_start = r_s2 & ~r_s3;

    // ------------------------------------------------------------------
    // Write queue
    // ------------------------------------------------------------------
    logic [23:0]     r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic            w_push;
    logic            w_pop;
    logic [23:0]     w_head;

    // Ready comes from the registered count alone, so a pop in the same cycle
    // does not open a slot for a push while the queue is full
    assign req_ready = (r_count != c_FULL);
    assign w_push    = req_valid & req_ready;
    assign w_pop     = w_slot_start & (r_count != '0);
    assign w_head    = r_mem[r_rd_ptr];

    // Queue storage. This array has no reset because the count controls
    // which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {req_addr, req_data};
        end
    end

    // Pointers wrap naturally since the depth is a power of two
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
        end
    end

    // Occupancy. A simultaneous push and pop cancel out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_AW + 1)'(1);
                2'b01:   r_count <= r_count - (c_AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Bus driver: IDLE / DRIVE, re-decided only at each slot boundary
    // ------------------------------------------------------------------
    logic [0:0]  r_state;
    logic [7:0]  r_rga;
    logic [15:0] r_db_out;
    logic        r_wr_strobe;

    // Load the bus from the queue head at slot start, or park on the NO-OP
    // register. When parked, db_out keeps its last value because the driver
    // is off.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_rga       <= IDLE_RGA;
            r_db_out    <= '0;
            r_wr_strobe <= 1'b0;
        end else begin
            r_wr_strobe <= w_pop;
            if (w_slot_start) begin
                if (w_pop) begin
                    r_state  <= c_DRIVE;
                    r_rga    <= w_head[23:16];
                    r_db_out <= w_head[15:0];
                end else begin
                    r_state  <= c_IDLE;
                    r_rga    <= IDLE_RGA;
                end
            end
        end
    end

    assign rga       = r_rga;
    assign db_out    = r_db_out;
    assign db_oen    = (r_state == c_DRIVE);
    assign wr_strobe = r_wr_strobe;
    assign busy      = (r_count != '0) | db_oen;

endmodule
`default_nettype wire
